cla_add_sequencer: RTL and testbench

- Initiator for the 4-bit `cla_adder` en/ready interface.
- Accepts WIDTH-bit add or subtract requests from the datapath and issues them to the adder one 4-bit chunk at a time, least significant first, chaining the carry.
- Returns a registered WIDTH-bit result with carry, signed-overflow and zero flags, or an error on adder timeout.
- Sits between the ALU decode logic and the single shared `cla_adder` instance.

---
 rtl/cla_seq_pkg.sv | 17 +
 rtl/cla_add_sequencer_if.sv | 22 ++
 rtl/seq_timeout.sv | 23 ++
 rtl/cla_add_sequencer.sv | 142 ++++++++++++++
 tb/tb_cla_add_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/cla_seq_pkg.sv
// Shared types and sizing helpers for the chunked carry-lookahead add sequencer.
package cla_seq_pkg;

  localparam int CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    DONE
  } seq_state_e;

  function automatic int num_chunks(input int width);
    return width / CHUNK;
  endfunction

endpackage

// File: rtl/cla_add_sequencer_if.sv
// Request/ready bus between the sequencer (master) and the shared 4-bit cla_adder (slave).
interface cla_add_sequencer_if;
  import cla_seq_pkg::*;

  logic             add_en;
  logic [CHUNK-1:0] add_a;
  logic [CHUNK-1:0] add_b;
  logic             add_cin;
  logic             add_ready;
  logic [CHUNK-1:0] add_out;
  logic             add_cout;

  modport master (
    output add_en, add_a, add_b, add_cin,
    input  add_ready, add_out, add_cout
  );

  modport slave (
    input  add_en, add_a, add_b, add_cin,
    output add_ready, add_out, add_cout
  );
endinterface

// File: rtl/seq_timeout.sv
// Clearable up-counter that flags when it has sat at TIMEOUT-1; holds there until cleared.
module seq_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  assign term = (cnt == CW'(TIMEOUT - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (clr)          cnt <= '0;
    else if (en && !term)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cla_add_sequencer.sv
// Issues WIDTH-bit add/sub to a shared 4-bit adder one chunk at a time, LS chunk first,
// and returns a registered result with carry/overflow/zero flags or a timeout error.
module cla_add_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 carry,
  output logic                 overflow,
  output logic                 zero,
  output logic                 err,
  cla_add_sequencer_if.master  bus
);
  localparam int N  = num_chunks(WIDTH);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  seq_state_e       state;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cy_q;
  logic [IW-1:0]    idx;
  logic             en_q;
  logic             last;
  logic             abort;
  logic             tmo_clr;
  logic             tmo_term;
  logic [WIDTH-1:0] fin_result;

  assign bus.add_en  = en_q;
  assign bus.add_a   = a_q[int'(idx)*CHUNK +: CHUNK];
  assign bus.add_b   = b_q[int'(idx)*CHUNK +: CHUNK];
  assign bus.add_cin = cy_q;

  assign last = (idx == IW'(N - 1));

  // The counter restarts whenever the FSM moves, so it only measures time stuck in one state.
  assign tmo_clr = (state == IDLE) || (state == DONE) ||
                   ((state == ISSUE) && bus.add_ready) ||
                   ((state == GAP)   && !bus.add_ready);
  assign abort   = tmo_term && (((state == ISSUE) && !bus.add_ready) ||
                                ((state == GAP)   &&  bus.add_ready));

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    fin_result = sum_q;
    fin_result[WIDTH-1 -: CHUNK] = bus.add_out;
  end

  seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmo_clr),
    .en   (busy),
    .term (tmo_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      cy_q     <= 1'b0;
      idx      <= '0;
      en_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= DONE;
        en_q     <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b1;
        err      <= 1'b1;
        result   <= '0;
        carry    <= 1'b0;
        overflow <= 1'b0;
        zero     <= 1'b1;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              a_q   <= op_a;
              b_q   <= sub ? ~op_b : op_b;
              cy_q  <= sub;
              idx   <= '0;
              en_q  <= 1'b1;
              busy  <= 1'b1;
              state <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
          ISSUE: begin
            if (bus.add_ready) begin
              sum_q[int'(idx)*CHUNK +: CHUNK] <= bus.add_out;
              cy_q <= bus.add_cout;
              en_q <= 1'b0;
              if (last) begin
                state    <= DONE;
                busy     <= 1'b0;
                done     <= 1'b1;
                err      <= 1'b0;
                result   <= fin_result;
                carry    <= bus.add_cout;
                overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                            (bus.add_out[CHUNK-1] != a_q[WIDTH-1]);
                zero     <= ~|fin_result;
              end else begin
                idx   <= idx + 1'b1;
                state <= GAP;
              end
            end
          end
          GAP: begin
            // Wait for the adder to drop ready so the previous chunk's ready is never reused.
            if (!bus.add_ready) begin
              en_q  <= 1'b1;
              state <= ISSUE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cla_add_sequencer.sv
// Directed bench for cla_add_sequencer with a behavioural 4-bit adder and a result scoreboard.
module tb_cla_add_sequencer;
  localparam int W   = 8;
  localparam int TO  = 16;
  localparam int R   = 2;
  localparam int N   = W / 4;
  localparam int BUDGET = 200;

  typedef struct {
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done, carry, overflow, zero, err;
  logic [W-1:0] result;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  // Adder model: ready R cycles after add_en rises, drops with add_en, or never when hung.
  logic       hang = 1'b0;
  int         mcnt;
  int         xacts;
  logic       cin_log[$];

  cla_add_sequencer_if bus ();

  cla_add_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sub     (sub),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carry   (carry),
    .overflow(overflow),
    .zero    (zero),
    .err     (err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            mcnt <= 0;
    else if (!bus.add_en)  mcnt <= 0;
    else if (mcnt < R)     mcnt <= mcnt + 1;
  end

  assign bus.add_ready = bus.add_en && !hang && (mcnt == R);
  assign {bus.add_cout, bus.add_out} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

  always @(posedge clk) begin
    if (bus.add_en && bus.add_ready) begin
      xacts <= xacts + 1;
      cin_log.push_back(bus.add_cin);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t       e;
    logic [W:0] full;
    if (s) full = {1'b0, a} + {1'b0, ~b} + 1'b1;
    else   full = {1'b0, a} + {1'b0, b};
    e.result   = full[W-1:0];
    e.carry    = full[W];
    e.overflow = s ? ((a[W-1] != b[W-1]) && (e.result[W-1] != a[W-1]))
                   : ((a[W-1] == b[W-1]) && (e.result[W-1] != a[W-1]));
    e.zero     = (e.result == '0);
    e.err      = 1'b0;
    return e;
  endfunction

  // Drives one request; latency counts clock edges from the accepting edge through the done edge.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input bit timeout, input int stray_at);
    exp_t e;
    int   cycles;
    int   exp_lat;
    if (timeout) begin
      e.result = '0; e.carry = 1'b0; e.overflow = 1'b0; e.zero = 1'b1; e.err = 1'b1;
      exp_lat = TO + 1;
    end else begin
      e = model(a, b, s);
      exp_lat = N * (R + 2);
    end
    @(negedge clk);
    sb_q.push_back(e);
    xacts = 0;
    cin_log.delete();
    start = 1'b1; op_a = a; op_b = b; sub = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    cycles = 1;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_en_rise"}, bus.add_en, 1);
    while (!done && cycles < BUDGET) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == stray_at) begin
        start = 1'b1; op_a = 8'hAA; op_b = 8'h55; sub = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, cycles, exp_lat);
    check({tag, "_sb_avail"}, sb_q.size() > 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_result"},   result,   e.result);
      check({tag, "_carry"},    carry,    e.carry);
      check({tag, "_overflow"}, overflow, e.overflow);
      check({tag, "_zero"},     zero,     e.zero);
      check({tag, "_err"},      err,      e.err);
    end
    check({tag, "_busy_done"}, busy, 0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int done_cnt;
    #12;
    check("rst_add_en", bus.add_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {carry, overflow, zero, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_op("add_1_2", 8'h01, 8'h02, 1'b0, 1'b0, -1);
    check("add_1_2_xacts", xacts, N);
    do_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, -1);
    check("add_0f_01_ncin", cin_log.size(), 2);
    if (cin_log.size() == 2) begin
      check("add_0f_01_cin0", cin_log[0], 0);
      check("add_0f_01_cin1", cin_log[1], 1);
    end
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, -1);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, -1);
    do_op("sub_05_05", 8'h05, 8'h05, 1'b1, 1'b0, -1);
    do_op("sub_03_05", 8'h03, 8'h05, 1'b1, 1'b0, -1);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, -1);

    hang = 1'b1;
    do_op("timeout", 8'h12, 8'h34, 1'b0, 1'b1, 6);
    check("timeout_en_low", bus.add_en, 0);
    hang = 1'b0;

    // Abandon a request mid-ISSUE with an asynchronous reset.
    @(negedge clk);
    start = 1'b1; op_a = 8'h55; op_b = 8'h22; sub = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    check("mid_en_before", bus.add_en, 1);
    rst_n = 1'b0;
    #1;
    check("mid_en_async", bus.add_en, 0);
    check("mid_busy", busy, 0);
    check("mid_result", result, 0);
    check("mid_flags", {done, carry, overflow, zero, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("mid_no_done", done_cnt, 0);

    do_op("add_10_20", 8'h10, 8'h20, 1'b0, 1'b0, -1);
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
